// File: rtl/mem_controller.sv
// Memory-port responder: runs one cache-line read or write from the arbiter as a
// tagged 64-bit bus request followed by eight data beats, then pulses completion.
module mem_controller #(
  parameter int LINE_BITS = 512,
  parameter int BUS_BITS  = 64,
  parameter int TAG_BITS  = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          mem_address,
  input  logic [LINE_BITS-1:0] mem_data_in,
  input  logic                 mem_req,
  input  logic                 mem_wr_en,
  output logic [LINE_BITS-1:0] mem_data_out,
  output logic                 mem_operation_complete,
  output logic                 bus_reqcyc,
  output logic [BUS_BITS-1:0]  bus_req,
  output logic [TAG_BITS-1:0]  bus_reqtag,
  input  logic                 bus_reqack,
  input  logic                 bus_respcyc,
  input  logic [BUS_BITS-1:0]  bus_resp,
  input  logic [TAG_BITS-1:0]  bus_resptag,
  output logic                 bus_respack
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_RD_BEATS = 3'd2,
    S_WR_BEATS = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic [63:0] LINE_MASK = 64'hFFFF_FFFF_FFFF_FFC0;

  state_e                 state_q, state_d;
  logic [2:0]             beat_q, beat_d;
  logic [63:0]            addr_q, addr_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [LINE_BITS-1:0]   rdata_q, rdata_d;
  logic [LINE_BITS-1:0]   dout_q, dout_d;
  logic                   is_wr_q, is_wr_d;
  logic [TAG_BITS-1:0]    tag_s;
  logic [8:0]             lsb_s;
  logic                   beat_ok_s;

  // Bit 12 marks a read, [11:8] = 0001 routes the request to memory.
  assign tag_s        = {~is_wr_q, 4'b0001, 8'h00};
  assign lsb_s        = {beat_q, 6'd0};
  assign beat_ok_s    = bus_respcyc && (bus_resptag == tag_s);
  assign mem_data_out = dout_q;

  // Next-state, datapath and bus-output decode.
  always_comb begin
    state_d                = state_q;
    beat_d                 = beat_q;
    addr_d                 = addr_q;
    wdata_d                = wdata_q;
    rdata_d                = rdata_q;
    dout_d                 = dout_q;
    is_wr_d                = is_wr_q;
    bus_reqcyc             = 1'b0;
    bus_req                = '0;
    bus_reqtag             = '0;
    bus_respack            = 1'b0;
    mem_operation_complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          addr_d  = mem_address & LINE_MASK;
          wdata_d = mem_data_in;
          is_wr_d = mem_wr_en;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = addr_q;
        bus_reqtag = tag_s;
        if (bus_reqack) begin
          beat_d  = 3'd0;
          state_d = is_wr_q ? S_WR_BEATS : S_RD_BEATS;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WR_BEATS: begin
        bus_reqcyc = 1'b1;
        bus_req    = wdata_q[lsb_s +: BUS_BITS];
        bus_reqtag = tag_s;
        beat_d     = beat_q + 3'd1;
        if (beat_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WR_BEATS;
        end
      end
      S_RD_BEATS: begin
        if (beat_ok_s) begin
          bus_respack                = 1'b1;
          rdata_d[lsb_s +: BUS_BITS] = bus_resp;
          beat_d                     = beat_q + 3'd1;
          // The finished line is published as the pulse goes out.
          if (beat_q == 3'd7) begin
            dout_d  = rdata_d;
            state_d = S_DONE;
          end else begin
            state_d = S_RD_BEATS;
          end
        end else begin
          state_d = S_RD_BEATS;
        end
      end
      S_DONE: begin
        mem_operation_complete = 1'b1;
        state_d                = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beat_q  <= 3'd0;
      addr_q  <= 64'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      is_wr_q <= is_wr_d;
    end
  end

endmodule
